song_sequencer: RTL and testbench

- Sits directly downstream of the song-selection MCU. Consumes `play`, `reset_player` and `song`, and returns `song_done` to the MCU.
- Walks the selected song's entries in an external synchronous song ROM and hands each {note, duration} pair to the note player with a one-cycle `new_note` strobe.
- Waits for the note player's `note_done` before advancing to the next entry.
- Supports pause/resume via `play`, early end-of-song markers, and restart on `reset_player`.

---
 rtl/song_sequencer_pkg.sv | 31 +++
 rtl/song_sequencer_if.sv | 25 ++
 rtl/song_idx_counter.sv | 23 ++
 rtl/song_sequencer.sv | 96 +++++++++
 tb/tb_song_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/song_sequencer_pkg.sv
// song_sequencer_pkg: shared widths, FSM state encoding and ROM word field helpers
// Used by song_sequencer, song_idx_counter and song_sequencer_if.
package song_sequencer_pkg;
    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int IDX_W    = 5;
    localparam int SONG_W   = 4;
    localparam int ADDR_W   = SONG_W + IDX_W;
    localparam int WORD_W   = NOTE_W + DUR_W;
    localparam int NOTE_LSB = DUR_W;
    localparam int DUR_LSB  = 0;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    localparam logic [DUR_W-1:0]  DUR_END   = '0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LOAD      = 3'd2,
        WAIT_NOTE = 3'd3,
        DONE      = 3'd4
    } state_t;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_LSB +: DUR_W];
    endfunction
endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: MCU, song ROM and note player signals of the sequencer
// master: MCU/ROM/note-player side; slave: the sequencer itself.
interface song_sequencer_if;
    import song_sequencer_pkg::*;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              new_note;
    logic              song_done;

    modport master (
        output play, reset_player, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );

    modport slave (
        input  play, reset_player, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );
endinterface

// File: rtl/song_idx_counter.sv
// song_idx_counter: entry index within the current song, with clear, increment and last-entry flag
// Ports: clk, reset (async active-low), i_clr, i_inc, o_idx, o_last.
module song_idx_counter
    import song_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_idx <= '0;
        else if (i_clr) r_idx <= '0;
        else if (i_inc) r_idx <= r_idx + 1'b1;
    end

    assign o_idx  = r_idx;
    assign o_last = &r_idx;
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song's ROM entries and hands {note, duration} to the note player
// Ports: clk, reset (async active-low), bus (slave): play/reset_player/song from the MCU,
// rom_addr/rom_data to the registered song ROM, note/duration/new_note/note_done with the
// note player, song_done back to the MCU.
module song_sequencer
    import song_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    song_sequencer_if.slave     bus
);
    state_t            r_state, w_next;
    logic [NOTE_W-1:0] r_note, w_note;
    logic [DUR_W-1:0]  r_dur, w_dur;
    logic              r_new, w_new;
    logic              r_done, w_done;
    logic              w_clr, w_inc, w_last;
    logic [IDX_W-1:0]  w_idx;

    song_idx_counter u_idx (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_note  <= NOTE_REST;
            r_dur   <= '0;
            r_new   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_note  <= w_note;
            r_dur   <= w_dur;
            r_new   <= w_new;
            r_done  <= w_done;
        end
    end

    // Strobes are computed for the state being left, so they appear in the following cycle.
    always_comb begin
        w_next = r_state;
        w_note = r_note;
        w_dur  = r_dur;
        w_new  = 1'b0;
        w_done = 1'b0;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        if (bus.reset_player) begin
            w_next = IDLE;
            w_note = NOTE_REST;
            w_dur  = '0;
            w_clr  = 1'b1;
        end else begin
            case (r_state)
                IDLE:  w_next = bus.play ? FETCH : IDLE;
                FETCH: w_next = LOAD;
                LOAD: begin
                    if (word_dur(bus.rom_data) == DUR_END) begin
                        w_next = DONE;
                    end else begin
                        w_next = WAIT_NOTE;
                        w_note = word_note(bus.rom_data);
                        w_dur  = word_dur(bus.rom_data);
                        w_new  = 1'b1;
                    end
                end
                WAIT_NOTE: begin
                    if (bus.note_done) begin
                        w_inc  = !w_last;
                        w_next = w_last ? DONE : (bus.play ? FETCH : IDLE);
                    end
                end
                DONE: begin
                    w_next = IDLE;
                    w_note = NOTE_REST;
                    w_dur  = '0;
                    w_clr  = 1'b1;
                    w_done = 1'b1;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    assign bus.rom_addr  = {bus.song, w_idx};
    assign bus.note      = r_note;
    assign bus.duration  = r_dur;
    assign bus.new_note  = r_new;
    assign bus.song_done = r_done;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench; expected note/done events are derived from the song table
module tb_song_sequencer;
    import song_sequencer_pkg::*;

    typedef struct packed {
        logic              done;
        logic [ADDR_W-1:0] addr;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } evt_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    song_sequencer_if bus();

    song_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] rom [0:(1<<ADDR_W)-1];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_evt = 0;
    int t_evt = 0;
    evt_t sb[$];
    evt_t g_evt, e_evt;
    logic rp_prev = 1'b0;
    logic [NOTE_W-1:0] hold_note = '0;
    logic [DUR_W-1:0]  hold_dur = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rp_prev <= bus.reset_player;
    end

    // Monitor: every strobe is matched against the scoreboard; between strobes note/duration must hold.
    always @(negedge clk) begin
        if (!reset) begin
            hold_note = '0;
            hold_dur = '0;
        end else begin
            if (rp_prev) begin
                hold_note = '0;
                hold_dur = '0;
            end
            if (bus.new_note || bus.song_done) begin
                g_evt = {bus.song_done, bus.rom_addr, bus.note, bus.duration};
                checks++;
                if (bus.new_note && bus.song_done) begin
                    failures++;
                    $display("FAIL strobes: new_note and song_done both high, got=%h", g_evt);
                end else if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: got=%h, none expected", g_evt);
                end else begin
                    e_evt = sb.pop_front();
                    if (g_evt !== e_evt) begin
                        failures++;
                        $display("FAIL event: got done/addr/note/dur=%h expected=%h", g_evt, e_evt);
                    end
                    hold_note = e_evt.note;
                    hold_dur = e_evt.dur;
                end
                n_evt++;
                t_evt = cyc;
            end else begin
                checks++;
                if (bus.note !== hold_note || bus.duration !== hold_dur) begin
                    failures++;
                    $display("FAIL hold: note=%h dur=%h expected note=%h dur=%h",
                             bus.note, bus.duration, hold_note, hold_dur);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    task automatic wait_evt(input int base, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (n_evt == base) begin
            tick();
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL timeout: no strobe within 200 cycles");
                ok = 1'b0;
                return;
            end
        end
    endtask

    // Reference: a song plays its entries in order until a zero duration or the last entry.
    function automatic void push_song(input logic [SONG_W-1:0] s);
        logic [WORD_W-1:0] w;
        logic [IDX_W-1:0] i5;
        for (int i = 0; i < (1 << IDX_W); i++) begin
            i5 = IDX_W'(i);
            w = rom[{s, i5}];
            if (w[DUR_W-1:0] == 0) begin
                sb.push_back({1'b1, s, {IDX_W{1'b0}}, {NOTE_W{1'b0}}, {DUR_W{1'b0}}});
                return;
            end
            sb.push_back({1'b0, s, i5, w[WORD_W-1:DUR_W], w[DUR_W-1:0]});
        end
        sb.push_back({1'b1, s, {IDX_W{1'b0}}, {NOTE_W{1'b0}}, {DUR_W{1'b0}}});
    endfunction

    task automatic run_song(input logic [SONG_W-1:0] s, input int pause_at, input int rst_at);
        int k, base, c0;
        bit ok, spur;
        bus.song = s;
        bus.reset_player = 1'b1;
        tick();
        bus.reset_player = 1'b0;
        chk("idle_addr", 32'(bus.rom_addr), 32'({s, 5'd0}));
        push_song(s);
        base = n_evt;
        c0 = cyc;
        bus.play = 1'b1;
        wait_evt(base, ok);
        if (!ok) return;
        if (!bus.song_done) chk("play_latency", t_evt - c0, 3);
        k = 0;
        forever begin
            if (bus.song_done) begin
                bus.play = 1'b0;
                chk("done_addr", 32'(bus.rom_addr), 32'({s, 5'd0}));
                tick();
                chk("done_width", 32'(bus.song_done), 0);
                return;
            end
            repeat ($urandom_range(0, 3)) tick();
            base = n_evt;
            c0 = cyc;
            if (k == rst_at) begin
                bus.note_done = 1'b1;
                bus.reset_player = 1'b1;
                bus.play = 1'b0;
                tick();
                bus.note_done = 1'b0;
                bus.reset_player = 1'b0;
                sb.delete();
                repeat (4) tick();
                chk("restart_idx", 32'(bus.rom_addr), 32'({s, 5'd0}));
                chk("restart_quiet", n_evt, base);
                return;
            end else if (k == pause_at) begin
                bus.note_done = 1'b1;
                bus.play = 1'b0;
                tick();
                bus.note_done = 1'b0;
                repeat (9) tick();
                chk("pause_quiet", n_evt, base);
                chk("pause_idx", 32'(bus.rom_addr), 32'({s, 5'(k + 1)}));
                c0 = cyc;
                bus.play = 1'b1;
                wait_evt(base, ok);
                if (!ok) return;
                if (!bus.song_done) chk("resume_latency", t_evt - c0, 3);
            end else begin
                spur = (k % 3 == 1) && sb.size() > 0 && !sb[0].done;
                bus.note_done = 1'b1;
                tick();
                if (spur) begin
                    tick();
                    tick();
                end
                bus.note_done = 1'b0;
                wait_evt(base, ok);
                if (!ok) return;
                if (!bus.song_done) chk("next_latency", t_evt - c0, 3);
            end
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit ok;
        bus.play = 1'b0;
        bus.reset_player = 1'b0;
        bus.song = '0;
        bus.note_done = 1'b0;
        for (int a = 0; a < (1 << ADDR_W); a++)
            rom[a] = {NOTE_W'($urandom), DUR_W'($urandom_range(1, (1 << DUR_W) - 1))};
        rom[{4'd3, 5'd2}] = {6'h15, 6'd0};
        for (int a = 8 << IDX_W; a < (1 << ADDR_W); a++)
            if ($urandom_range(0, 15) == 0) rom[a][DUR_W-1:0] = '0;
        #2 reset = 1'b0;
        repeat (3) tick();
        chk("rst_note", 32'(bus.note), 0);
        chk("rst_dur", 32'(bus.duration), 0);
        chk("rst_new", 32'(bus.new_note), 0);
        chk("rst_done", 32'(bus.song_done), 0);
        chk("rst_addr", 32'(bus.rom_addr), 0);
        reset = 1'b1;
        tick();

        bus.song = 4'd4;
        bus.reset_player = 1'b1;
        tick();
        bus.reset_player = 1'b0;
        push_song(4'd4);
        base = n_evt;
        bus.play = 1'b1;
        wait_evt(base, ok);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_note", 32'(bus.note), 0);
        chk("async_dur", 32'(bus.duration), 0);
        chk("async_new", 32'(bus.new_note), 0);
        chk("async_done", 32'(bus.song_done), 0);
        sb.delete();
        bus.play = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_song(4'd2, -1, -1);
        run_song(4'd1, -1, -1);
        run_song(4'd3, -1, -1);
        run_song(4'd5, 5, -1);
        run_song(4'd6, -1, 7);
        run_song(4'd6, -1, -1);
        for (int i = 0; i < 5; i++)
            run_song(SONG_W'($urandom_range(7, 15)), $urandom_range(0, 30), -1);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
